// File: rtl/qspi_rx_sampler_if.sv
// Receive-side control and byte-stream bundle between the QSPI sampler and the AHB register block.
interface qspi_rx_sampler_if;
    logic        rx_start_i;
    logic [15:0] rx_len_i;
    logic [1:0]  rx_mode_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic        rx_busy_o;
    logic        rx_done_o;
    logic        rx_ovf_o;

    modport slave (
        input  rx_start_i, rx_len_i, rx_mode_i, rx_ready_i,
        output rx_data_o, rx_valid_o, rx_busy_o, rx_done_o, rx_ovf_o
    );

    modport master (
        output rx_start_i, rx_len_i, rx_mode_i, rx_ready_i,
        input  rx_data_o, rx_valid_o, rx_busy_o, rx_done_o, rx_ovf_o
    );
endinterface

// File: rtl/qspi_rx_sampler.sv
// QSPI receive sampler: samples flash data on SCLK rising edges in x1/x2/x4 mode, packs bytes MSB-first into a FIFO.
// Latency: a completed byte is visible on rx_data_o/rx_valid_o the cycle after its last sampling strobe.
// Backpressure: FIFO absorbs FIFO_DEPTH bytes; a byte arriving when full (and no pop) is dropped and rx_ovf_o is set.
module qspi_rx_sampler #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic               ahb_clk_i,
    input  logic               ahb_rst_i,
    input  logic               qspi_clk_i,
    input  logic               qspi_fullrate_i,
    input  logic [3:0]         qspi_io_i,
    qspi_rx_sampler_if.slave   rx_if
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic               clk_d;
    logic               strobe;
    logic [1:0]         mode_q;
    logic [15:0]        byte_cnt_q;
    logic [2:0]         bit_cnt_q;
    logic [2:0]         last_bit;
    logic [7:0]         sr_q, sr_d;
    logic               start_acc;
    logic               byte_done;
    logic               ovf_q;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW:0]   wr_ptr_q, rd_ptr_q;
    logic               fifo_empty, fifo_full;
    logic               push, pop, drop;

    assign strobe    = qspi_fullrate_i | (qspi_clk_i & ~clk_d);
    assign start_acc = rx_if.rx_start_i & (state_q == ST_IDLE);
    assign byte_done = (state_q == ST_SHIFT) & strobe & (bit_cnt_q == last_bit);

    // Mode 2'b11 falls through to the single-lane default.
    always_comb begin
        sr_d     = {sr_q[6:0], qspi_io_i[1]};
        last_bit = 3'd7;
        case (mode_q)
            2'b01: begin
                sr_d     = {sr_q[5:0], qspi_io_i[1:0]};
                last_bit = 3'd3;
            end
            2'b10: begin
                sr_d     = {sr_q[3:0], qspi_io_i[3:0]};
                last_bit = 3'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (rx_if.rx_start_i) state_d = (rx_if.rx_len_i == 16'd0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (byte_done && byte_cnt_q == 16'd1) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ahb_clk_i or negedge ahb_rst_i) begin
        if (!ahb_rst_i) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_ff @(posedge ahb_clk_i or negedge ahb_rst_i) begin
        if (!ahb_rst_i) begin
            clk_d      <= 1'b0;
            mode_q     <= 2'b00;
            byte_cnt_q <= 16'd0;
            bit_cnt_q  <= 3'd0;
            sr_q       <= 8'd0;
            ovf_q      <= 1'b0;
        end else begin
            clk_d <= qspi_clk_i;
            if (start_acc) begin
                mode_q     <= rx_if.rx_mode_i;
                byte_cnt_q <= rx_if.rx_len_i;
                bit_cnt_q  <= 3'd0;
                sr_q       <= 8'd0;
            end else if (state_q == ST_SHIFT && strobe) begin
                sr_q      <= sr_d;
                bit_cnt_q <= byte_done ? 3'd0 : bit_cnt_q + 3'd1;
                if (byte_done) byte_cnt_q <= byte_cnt_q - 16'd1;
            end
            if (start_acc)  ovf_q <= 1'b0;
            else if (drop)  ovf_q <= 1'b1;
        end
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign pop        = ~fifo_empty & rx_if.rx_ready_i;
    assign push       = byte_done & (~fifo_full | pop);
    assign drop       = byte_done & fifo_full & ~pop;

    always_ff @(posedge ahb_clk_i or negedge ahb_rst_i) begin
        if (!ahb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge ahb_clk_i) begin
        if (push) mem[wr_ptr_q[FIFO_AW-1:0]] <= sr_d;
    end

    assign rx_if.rx_data_o  = fifo_empty ? 8'h00 : mem[rd_ptr_q[FIFO_AW-1:0]];
    assign rx_if.rx_valid_o = ~fifo_empty;
    assign rx_if.rx_busy_o  = (state_q == ST_SHIFT);
    assign rx_if.rx_done_o  = (state_q == ST_DONE);
    assign rx_if.rx_ovf_o   = ovf_q;

endmodule

// File: tb/tb_qspi_rx_sampler.sv
// Directed bench for qspi_rx_sampler; received bytes are checked against a scoreboard queue by a separate monitor.
module tb_qspi_rx_sampler;

    logic       clk;
    logic       rst_n;
    logic       qclk;
    logic       fullrate;
    logic [3:0] io;

    int         n_vec  = 0;
    int         n_miss = 0;
    logic [7:0] sb [$];

    qspi_rx_sampler_if bus ();

    qspi_rx_sampler #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .ahb_clk_i       (clk),
        .ahb_rst_i       (rst_n),
        .qspi_clk_i      (qclk),
        .qspi_fullrate_i (fullrate),
        .qspi_io_i       (io),
        .rx_if           (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every byte consumed from the DUT must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && bus.rx_valid_o && bus.rx_ready_i) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_byte: got %0h, expected none", bus.rx_data_o);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (bus.rx_data_o !== e) begin
                    n_miss++;
                    $display("FAIL rx_byte: got %0h, expected %0h", bus.rx_data_o, e);
                end
            end
        end
    end

    task automatic start_burst(input logic [15:0] len, input logic [1:0] mode);
        bus.rx_start_i = 1'b1;
        bus.rx_len_i   = len;
        bus.rx_mode_i  = mode;
        tick();
        bus.rx_start_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard;
        bus.rx_ready_i = 1'b1;
        guard = 0;
        while (bus.rx_valid_o && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        chk({name, "_valid_low"}, bus.rx_valid_o, 0);
        chk({name, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        logic [7:0] dual_bytes [6];
        logic [3:0] quad_nibs  [10];
        logic [7:0] single_bits;
        logic [1:0] ch;
        int         busy_cnt;

        dual_bytes = '{8'h1B, 8'hE4, 8'h27, 8'hD8, 8'h55, 8'hAA};
        quad_nibs  = '{4'hC, 4'h3, 4'h5, 4'hA, 4'h9, 4'h6, 4'h0, 4'hF, 4'hF, 4'h0};
        single_bits = 8'hB2;

        rst_n = 1'b0;
        qclk = 1'b0;
        fullrate = 1'b0;
        io = 4'h0;
        bus.rx_start_i = 1'b0;
        bus.rx_len_i   = 16'd0;
        bus.rx_mode_i  = 2'b00;
        bus.rx_ready_i = 1'b1;
        #3;
        chk("reset_valid", bus.rx_valid_o, 0);
        chk("reset_busy",  bus.rx_busy_o, 0);
        chk("reset_done",  bus.rx_done_o, 0);
        chk("reset_ovf",   bus.rx_ovf_o, 0);
        chk("reset_data",  bus.rx_data_o, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Quad, full rate: A,5,3,C -> 0xA5, 0x3C
        fullrate = 1'b1;
        sb.push_back(8'hA5);
        sb.push_back(8'h3C);
        start_burst(16'd2, 2'b10);
        busy_cnt = int'(bus.rx_busy_o);
        io = 4'hA; tick(); busy_cnt += int'(bus.rx_busy_o);
        io = 4'h5; tick(); busy_cnt += int'(bus.rx_busy_o);
        io = 4'h3; tick(); busy_cnt += int'(bus.rx_busy_o);
        io = 4'hC; tick(); busy_cnt += int'(bus.rx_busy_o);
        chk("quad_done_pulse", bus.rx_done_o, 1);
        chk("quad_busy_cycles", busy_cnt, 4);
        tick();
        chk("quad_done_one_cycle", bus.rx_done_o, 0);
        drain("quad");

        // Single, divided clock; lanes inverted during the low phase
        fullrate = 1'b0;
        qclk = 1'b0;
        sb.push_back(8'hB2);
        start_burst(16'd1, 2'b00);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("single_busy_after7", bus.rx_busy_o, 1);
            qclk = 1'b1;
            io = single_bits[7-i] ? 4'b0010 : 4'b1101;
            tick();
            if (i == 7) chk("single_done_after8", bus.rx_done_o, 1);
            tick();
            qclk = 1'b0;
            io = single_bits[7-i] ? 4'b1101 : 4'b0010;
            tick(); tick();
        end
        drain("single");

        // Zero length burst
        fullrate = 1'b1;
        start_burst(16'd0, 2'b10);
        chk("len0_done", bus.rx_done_o, 1);
        chk("len0_busy", bus.rx_busy_o, 0);
        tick();
        chk("len0_done_off", bus.rx_done_o, 0);
        chk("len0_no_push", bus.rx_valid_o, 0);

        // Dual, consumer stalled: 4 stored, 2 dropped
        bus.rx_ready_i = 1'b0;
        for (int b = 0; b < 4; b++) sb.push_back(dual_bytes[b]);
        start_burst(16'd6, 2'b01);
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 4; k++) begin
                ch = dual_bytes[b][7-2*k -: 2];
                io = {~ch, ch};
                tick();
            end
            if (b == 3) chk("dual_no_ovf_at_full", bus.rx_ovf_o, 0);
        end
        chk("dual_done", bus.rx_done_o, 1);
        chk("dual_ovf", bus.rx_ovf_o, 1);
        chk("dual_valid", bus.rx_valid_o, 1);
        drain("dual");

        // Quad len 5 with an ignored restart pulse mid-burst
        bus.rx_ready_i = 1'b0;
        sb.push_back(8'hC3);
        sb.push_back(8'h5A);
        sb.push_back(8'h96);
        sb.push_back(8'h0F);
        start_burst(16'd5, 2'b10);
        for (int n = 0; n < 10; n++) begin
            io = quad_nibs[n];
            if (n == 2) begin
                bus.rx_start_i = 1'b1;
                bus.rx_len_i   = 16'd1;
                bus.rx_mode_i  = 2'b00;
            end else begin
                bus.rx_start_i = 1'b0;
            end
            tick();
            if (n == 7) chk("restart_not_done_early", bus.rx_done_o, 0);
        end
        chk("restart_done", bus.rx_done_o, 1);
        chk("restart_ovf", bus.rx_ovf_o, 1);
        tick();
        bus.rx_ready_i = 1'b1;
        tick(); tick();
        bus.rx_ready_i = 1'b0;
        sb.push_back(8'h7E);
        start_burst(16'd1, 2'b10);
        chk("second_ovf_cleared", bus.rx_ovf_o, 0);
        chk("second_old_data_kept", bus.rx_valid_o, 1);
        io = 4'h7; tick();
        io = 4'hE; tick();
        chk("second_done", bus.rx_done_o, 1);
        drain("second");

        // Reset mid-burst, right after the first byte lands
        start_burst(16'd3, 2'b10);
        io = 4'h1; tick();
        io = 4'h2; tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus.rx_valid_o, 0);
        chk("midrst_busy",  bus.rx_busy_o, 0);
        chk("midrst_done",  bus.rx_done_o, 0);
        chk("midrst_data",  bus.rx_data_o, 0);
        tick();
        chk("midrst_done_hold", bus.rx_done_o, 0);
        rst_n = 1'b1;
        tick();
        chk("postrst_done", bus.rx_done_o, 0);
        chk("postrst_busy", bus.rx_busy_o, 0);
        chk("postrst_valid", bus.rx_valid_o, 0);
        sb.push_back(8'h9D);
        start_burst(16'd1, 2'b10);
        io = 4'h9; tick();
        io = 4'hD; tick();
        chk("postrst_burst_done", bus.rx_done_o, 1);
        drain("postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
